// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and helpers
// shared by the multi-cycle ALU and its iterator
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_MOD  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_LAND = 4'd7;
  localparam logic [3:0] OP_LOR  = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_NOT  = 4'd10;
  localparam logic [3:0] OP_LNOT = 4'd11;
  localparam logic [3:0] OP_SHR  = 4'd12;
  localparam logic [3:0] OP_SHL  = 4'd13;
  localparam logic [3:0] OP_INC  = 4'd14;
  localparam logic [3:0] OP_DEC  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_multicycle(
    input logic [3:0] op
  );
    return (op == OP_MUL) ||
           (op == OP_DIV) ||
           (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: W-step shift-add multiplier / restoring divider
// ports: start/mode(0 mul,1 div)/opa/b in; done pulse, lo/hi next-step values out
module alu_muldiv_iter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [W-1:0] opa,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  lo_q;
  logic [W-1:0]  hi_q;
  logic [W-1:0]  dv;
  logic          md;
  logic          busy;
  logic [CW-1:0] cnt;
  logic [W:0]    sum;
  logic [W:0]    r2;
  logic [W:0]    dif;

  // lo/hi carry the value after the current step so the
  // parent can register the final step on the done cycle
  always_comb begin
    sum = {1'b0, hi_q} + {1'b0, dv};
    r2  = {hi_q, lo_q[W-1]};
    dif = r2 - {1'b0, dv};
    lo  = lo_q;
    hi  = hi_q;
    if (md) begin
      if (!dif[W]) begin
        hi = dif[W-1:0];
        lo = {lo_q[W-2:0], 1'b1};
      end else begin
        hi = r2[W-1:0];
        lo = {lo_q[W-2:0], 1'b0};
      end
    end else if (lo_q[0]) begin
      {hi, lo} = {sum, lo_q[W-1:1]};
    end else begin
      {hi, lo} = {1'b0, hi_q, lo_q[W-1:1]};
    end
  end

  assign done = busy && (cnt == CW'(W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_q <= '0;
      hi_q <= '0;
      dv   <= '0;
      md   <= 1'b0;
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      lo_q <= opa;
      hi_q <= '0;
      dv   <= b;
      md   <= mode;
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      lo_q <= lo;
      hi_q <= hi;
      cnt  <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle W-bit ALU with accumulator and flags
// ports: in_valid/in_ready/a/b/opcode/use_acc in; out_valid/out_ready, result+flags, acc out
module alu_mc
  import alu_pkg::*;
#(
  parameter int           W         = 8,
  parameter logic [W-1:0] ACC_RESET = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   opcode,
  input  logic         use_acc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         carry,
  output logic         zero,
  output logic         neg,
  output logic         ovf,
  output logic         dz,
  output logic [W-1:0] acc
);

  state_t       state;
  state_t       nxt;
  logic [W-1:0] opa;
  logic         accept;
  logic         go_busy;
  logic [3:0]   op_r;
  logic [W-1:0] s_res;
  logic         s_c;
  logic         s_v;
  logic         s_dz;
  logic [W:0]   ext;
  logic         it_done;
  logic [W-1:0] it_lo;
  logic [W-1:0] it_hi;
  logic [W-1:0] m_res;

  localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  assign opa     = use_acc ? acc : a;
  assign accept  = in_valid && in_ready;
  // div/mod by zero short-circuits to the one-cycle path
  assign go_busy = is_multicycle(opcode) &&
                   !(opcode != OP_MUL && b == '0);

  always_comb begin
    s_res = '0;
    s_c   = 1'b0;
    s_v   = 1'b0;
    s_dz  = 1'b0;
    ext   = '0;
    unique case (opcode)
      OP_ADD: begin
        ext   = {1'b0, opa} + {1'b0, b};
        s_res = ext[W-1:0];
        s_c   = ext[W];
        s_v   = (opa[W-1] == b[W-1]) &&
                (s_res[W-1] != opa[W-1]);
      end
      OP_SUB: begin
        ext   = {1'b0, opa} - {1'b0, b};
        s_res = ext[W-1:0];
        s_c   = ext[W];
        s_v   = (opa[W-1] != b[W-1]) &&
                (s_res[W-1] != opa[W-1]);
      end
      OP_MUL: s_res = '0;
      OP_DIV: begin
        s_res = '1;
        s_dz  = 1'b1;
      end
      OP_MOD: begin
        s_res = opa;
        s_dz  = 1'b1;
      end
      OP_AND:  s_res = opa & b;
      OP_OR:   s_res = opa | b;
      OP_LAND: s_res = {{(W-1){1'b0}},
                        (opa != '0) && (b != '0)};
      OP_LOR:  s_res = {{(W-1){1'b0}},
                        (opa != '0) || (b != '0)};
      OP_XOR:  s_res = opa ^ b;
      OP_NOT:  s_res = ~opa;
      OP_LNOT: s_res = {{(W-1){1'b0}}, opa == '0};
      OP_SHR: begin
        s_res = opa >> 1;
        s_c   = opa[0];
      end
      OP_SHL: begin
        s_res = opa << 1;
        s_c   = opa[W-1];
      end
      OP_INC: begin
        ext   = {1'b0, opa} + (W+1)'(1);
        s_res = ext[W-1:0];
        s_c   = ext[W];
        s_v   = (opa == SMAX);
      end
      OP_DEC: begin
        ext   = {1'b0, opa} - (W+1)'(1);
        s_res = ext[W-1:0];
        s_c   = ext[W];
        s_v   = (opa == SMIN);
      end
    endcase
  end

  alu_muldiv_iter #(.W(W)) u_iter (
    .clk   (clk),
    .rst   (rst),
    .start (accept && go_busy),
    .mode  (opcode != OP_MUL),
    .opa   (opa),
    .b     (b),
    .done  (it_done),
    .lo    (it_lo),
    .hi    (it_hi)
  );

  assign m_res = (op_r == OP_MOD) ? it_hi : it_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt       = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          nxt = go_busy ? ST_BUSY : ST_DONE;
      end
      ST_BUSY: if (it_done) nxt = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) nxt = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) op_r <= OP_ADD;
    else if (accept) op_r <= opcode;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b0;
      neg    <= 1'b0;
      ovf    <= 1'b0;
      dz     <= 1'b0;
      acc    <= ACC_RESET;
    end else if (accept && !go_busy) begin
      result <= s_res;
      carry  <= s_c;
      zero   <= (s_res == '0);
      neg    <= s_res[W-1];
      ovf    <= s_v;
      dz     <= s_dz;
      acc    <= s_res;
    end else if (state == ST_BUSY && it_done) begin
      result <= m_res;
      carry  <= (op_r == OP_MUL) && (it_hi != '0);
      zero   <= (m_res == '0);
      neg    <= m_res[W-1];
      ovf    <= 1'b0;
      dz     <= 1'b0;
      acc    <= m_res;
    end
  end

endmodule
